// File: rtl/alu_pipe_if.sv
// alu_pipe_if -- request/response bundle for alu_pipe.
//   master : drives in_valid, a, b, ALUOp, out_ready; sees in_ready and results
//   slave  : the ALU side (alu_pipe)
//   in_valid/in_ready    : operation handshake (a, b, ALUOp qualified by in_valid)
//   out_valid/out_ready  : result handshake (Result, Zero, CarryOut, Overflow)
interface alu_pipe_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       ALUOp;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             CarryOut;
  logic             Overflow;

  modport master (
    output in_valid, a, b, ALUOp, out_ready,
    input  in_ready, out_valid, Result, Zero, CarryOut, Overflow
  );

  modport slave (
    input  in_valid, a, b, ALUOp, out_ready,
    output in_ready, out_valid, Result, Zero, CarryOut, Overflow
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe -- pipelined MIPS-style ALU with an iterative shift-add multiplier.
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_pipe_if.slave (operation in, registered Result/flags out)
// ALUOp: [3]=Ainvert, [2]=Bnegate (also adder carry-in), [1:0]=AND/OR/ADD/SLT.
// ALUOp 4'b1111 is an unsigned multiply taking WIDTH cycles; other ops have
// one cycle of latency and full throughput.
module alu_pipe #(
  parameter int WIDTH = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_pipe_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;

  logic              vld_p0;
  logic signed [WIDTH-1:0] a_p0, b_p0;
  logic [3:0]        op_p0;

  logic              vld_p1;
  logic [WIDTH-1:0]  res_p1;
  logic              zero_p1, c_p1, v_p1;

  logic [WIDTH-1:0]  mcand, mplier, acc, acc_nxt;

  logic              out_free, accept, is_mul, mul_done;

  // The p0 stage advances exactly when the output register can take a new
  // value, so a stalled consumer stalls both stages together.
  assign out_free = !vld_p1 || bus.out_ready;
  assign bus.in_ready = (state == IDLE) && out_free;
  assign accept   = bus.in_valid && bus.in_ready;
  assign is_mul   = (bus.ALUOp == 4'b1111);
  // Last shift-add step; held off if an older result still occupies the output.
  assign mul_done = (state == MUL) && (cnt == LAST) && out_free;
  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);

  assign bus.out_valid = vld_p1;
  assign bus.Result    = res_p1;
  assign bus.Zero      = zero_p1;
  assign bus.CarryOut  = c_p1;
  assign bus.Overflow  = v_p1;

  // ---- stage p0: operand capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
    end else if (out_free) begin
      vld_p0 <= accept && !is_mul;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !is_mul) begin
      a_p0  <= bus.a;
      b_p0  <= bus.b;
      op_p0 <= bus.ALUOp;
    end
  end

  // ---- multiplier FSM and iteration state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && is_mul) begin
            state <= MUL;
            cnt   <= '0;
          end
        end
        default: begin
          if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
          end else if (out_free) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept && is_mul) begin
      mcand  <= bus.a;
      mplier <= bus.b;
      acc    <= '0;
    end else if (state == MUL && cnt != LAST) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // ALU evaluated on the captured p0 operands.
  logic signed [WIDTH-1:0] opa, opb, add_s;
  logic             add_c, add_v;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  always_comb begin
    opa = op_p0[3] ? ~a_p0 : a_p0;
    opb = op_p0[2] ? ~b_p0 : b_p0;
    {add_c, add_s} = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, op_p0[2]};
    // Signed overflow: operands agree in sign but the sum does not.
    add_v = (opa[WIDTH-1] == opb[WIDTH-1]) && (add_s[WIDTH-1] != opa[WIDTH-1]);
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_p0[1:0])
      2'b00: alu_res = opa & opb;
      2'b01: alu_res = opa | opb;
      2'b10: begin
        alu_res = add_s;
        alu_c   = add_c;
        alu_v   = add_v;
      end
      default: begin
        alu_res = {{(WIDTH-1){1'b0}}, add_s[WIDTH-1] ^ add_v};
        alu_c   = add_c;
        alu_v   = add_v;
      end
    endcase
  end

  // ---- stage p1: registered result and flags ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      res_p1  <= '0;
      zero_p1 <= 1'b0;
      c_p1    <= 1'b0;
      v_p1    <= 1'b0;
    end else if (vld_p0 && out_free) begin
      vld_p1  <= 1'b1;
      res_p1  <= alu_res;
      zero_p1 <= (alu_res == '0);
      c_p1    <= alu_c;
      v_p1    <= alu_v;
    end else if (mul_done) begin
      vld_p1  <= 1'b1;
      res_p1  <= acc_nxt;
      zero_p1 <= (acc_nxt == '0);
      c_p1    <= 1'b0;
      v_p1    <= 1'b0;
    end else if (vld_p1 && bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W)) bus();
  alu_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       v;
  } vec_t;

  vec_t tbl[13];

  // {out_valid, Zero, CarryOut, Overflow, Result}
  logic [11:0] got;
  assign got = {bus.out_valid, bus.Zero, bus.CarryOut, bus.Overflow, bus.Result};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic vld, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = vld;
    bus.ALUOp    = op;
    bus.a        = a;
    bus.b        = b;
  endtask

  int stale;

  initial begin
    drive(1'b0, 4'h0, 8'h00, 8'h00);
    bus.out_ready = 1'b1;

    tbl[0]  = '{4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{4'b0110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{4'b0111, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{4'b1100, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{4'b0000, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{4'b0001, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{4'b0010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{4'b0110, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{4'b0111, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{4'b0110, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{4'b0111, 8'h80, 8'h01, 8'h01, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{4'b0010, 8'h40, 8'h20, 8'h60, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{4'b1101, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0};

    // Reset state
    #1 rst_n = 1'b0;
    #10;
    check("reset", {3'b0, got, bus.in_ready}, {3'b0, 12'h000, 1'b1});
    @(negedge clk) rst_n = 1'b1;

    // Single-cycle ops, one per table entry
    for (int i = 0; i < 13; i++) begin
      @(negedge clk) drive(1'b1, tbl[i].op, tbl[i].a, tbl[i].b);
      @(posedge clk); #1 bus.in_valid = 1'b0;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), {4'b0, got},
            {4'b0, 1'b1, tbl[i].z, tbl[i].c, tbl[i].v, tbl[i].res});
    end

    // MUL 13*11; an ADD held on the inputs during the multiply must wait
    @(negedge clk) drive(1'b1, 4'b1111, 8'd13, 8'd11);
    @(posedge clk); #1 drive(1'b1, 4'b0010, 8'h10, 8'h20);
    check("mul_busy0", {14'b0, bus.in_ready, bus.out_valid}, 16'h0000);
    for (int j = 1; j < 8; j++) begin
      @(posedge clk); #1;
      check($sformatf("mul_busy%0d", j), {14'b0, bus.in_ready, bus.out_valid}, 16'h0000);
    end
    @(posedge clk); #1;
    check("mul_product", {3'b0, got, bus.in_ready}, {3'b0, 1'b1, 3'b000, 8'h8F, 1'b1});
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("mul_next_op", {4'b0, got}, {4'b0, 1'b1, 3'b000, 8'h30});
    @(posedge clk); #1;
    check("mul_next_drain", {15'b0, bus.out_valid}, 16'h0000);

    // Back-to-back ADDs with out_ready low for 3 cycles
    @(negedge clk) drive(1'b1, 4'b0010, 8'h01, 8'h02);
    @(posedge clk); #1 drive(1'b1, 4'b0010, 8'h10, 8'h20);
    bus.out_ready = 1'b0;
    @(posedge clk); #1 drive(1'b1, 4'b0010, 8'h05, 8'h06);
    for (int j = 0; j < 3; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      check($sformatf("stall%0d", j), {3'b0, got, bus.in_ready}, {3'b0, 1'b1, 3'b000, 8'h03, 1'b0});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    check("stall_out2", {4'b0, got}, {4'b0, 1'b1, 3'b000, 8'h30});
    @(posedge clk); #1;
    check("stall_out3", {4'b0, got}, {4'b0, 1'b1, 3'b000, 8'h0B});
    @(posedge clk); #1;
    check("stall_drain", {15'b0, bus.out_valid}, 16'h0000);

    // Reset during iteration 4 of a MUL; then an ADD on the first edge after release
    @(negedge clk) drive(1'b1, 4'b1111, 8'hFF, 8'hFF);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("mid_mul_reset", {3'b0, got, bus.in_ready}, {3'b0, 12'h000, 1'b1});
    @(negedge clk) begin
      rst_n = 1'b1;
      drive(1'b1, 4'b0010, 8'h07, 8'h08);
    end
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_reset_add", {4'b0, got}, {4'b0, 1'b1, 3'b000, 8'h0F});
    stale = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid) stale++;
    end
    check("no_stale_product", 16'(stale), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64, datapath width in bits (legal range 4..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  block can accept an operation this cycle.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port ALUOp  input  4  operation: [3]=Ainvert, [2]=Bnegate, [1:0]=function.
REQ-009 SHALL have port out_valid  output  1  Result and flags are valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port Result  output  WIDTH  registered result.
REQ-012 SHALL have ports Zero, CarryOut, Overflow  output  1 each  registered flags.

Function
REQ-013 SHALL accept an operation on a rising edge where in_valid && in_ready, and SHALL capture a, b and ALUOp at that edge.
REQ-014 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready), combinationally.
REQ-015 SHALL form A' = ALUOp[3] ? ~a : a and B' = ALUOp[2] ? ~b : b, with adder carry-in = ALUOp[2].
REQ-016 SHALL compute for ALUOp[1:0]: 00 bitwise A'&B'; 01 bitwise A'|B'; 10 A'+B'+cin (mod 2^WIDTH); 11 SLT = {0..., sum[WIDTH-1]^ovf} (signed A' < signed B').
REQ-017 SHALL treat ALUOp 4'b1111 as MUL: unsigned a*b, low WIDTH bits, computed by an iterative shift-add over exactly WIDTH cycles.
REQ-018 SHALL set CarryOut = adder carry out of bit WIDTH-1 and Overflow = signed overflow of the add, for functions 10 and 11; both 0 for 00, 01 and MUL.
REQ-019 SHALL set Zero = 1 exactly when the registered Result is all zeros, for every operation.
REQ-020 SHALL implement FSM states IDLE and MUL: IDLE->MUL on accepting 4'b1111; MUL->IDLE on the edge writing the product; all other ops stay in IDLE.
REQ-021 SHALL, for non-MUL ops accepted at edge k, present Result/flags with out_valid=1 after edge k+1 (latency 1, throughput 1/cycle with out_ready=1).
REQ-022 SHALL, for MUL accepted at edge k, present the product with out_valid=1 after edge k+WIDTH; in_ready SHALL be 0 from after edge k until the product is written.
REQ-023 SHALL hold Result, flags and out_valid stable while out_valid && !out_ready.
REQ-024 SHALL clear out_valid on an edge where out_valid && out_ready and no new result is written; SHALL overwrite without a bubble when a result is consumed and a new one written on the same edge.
REQ-025 SHALL ignore a, b, ALUOp and in_valid while in_ready=0.
REQ-026 SHALL treat arithmetic wrap-around (e.g. all-ones + 1) as Result 0, CarryOut 1, Zero 1.

Reset
REQ-027 SHALL, while rst_n=0, immediately force state=IDLE, out_valid=0, Result=0, Zero=0, CarryOut=0, Overflow=0, iteration counter=0.
REQ-028 SHALL abandon an in-progress MUL on reset with no result produced; first acceptance is possible on the first edge after rst_n deasserts.

Verification
REQ-029 SHALL pass, WIDTH=8: ADD 0010, a=0x7F, b=0x01 -> Result 0x80, Overflow 1, CarryOut 0, Zero 0, one cycle after accept.
REQ-030 SHALL pass, WIDTH=8: SUB 0110, a=0x05, b=0x05 -> Result 0x00, Zero 1, CarryOut 1, Overflow 0; then SLT 0111, a=0xFF, b=0x01 -> Result 0x01.
REQ-031 SHALL pass, WIDTH=8: NOR 1100, a=0x00, b=0x00 -> Result 0xFF, Zero 0; AND 0000, a=0xF0, b=0x0F -> Result 0x00, Zero 1.
REQ-032 SHALL pass, WIDTH=8: MUL 1111, a=13, b=11 -> Result 0x8F, out_valid after exactly 8 edges, in_ready 0 throughout, next op accepted the following cycle.
REQ-033 SHALL pass back-to-back ADDs with out_ready held 0 for 3 cycles: first result stable, in_ready 0, no op lost or duplicated after out_ready returns to 1.
REQ-034 SHALL pass rst_n pulsed low mid-MUL (iteration 4 of 8) -> out_valid 0, in_ready 1 after release, no stale product ever emitted.
